canv_pix_write: RTL and testbench



---
 rtl/canv_pix_write.sv | 163 ++++++++++++++++
 tb/tb_canv_pix_write.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/canv_pix_write.sv
// canv_pix_write: clips pixel draw requests to the canvas and turns each survivor
// into a masked packed-pixel vram word write through a two-stage pipe (1 pixel/cycle).
module canv_pix_write #(
    parameter int CORDW  = 16,
    parameter int WORD   = 32,
    parameter int ADDRW  = 14,
    parameter int SHIFTW = 3,
    parameter int CIDXW  = 8,
    parameter int CNTW   = 16
) (
    input  logic                    clk_sys,
    input  logic                    rst_sys,
    input  logic [ADDRW-1:0]        addr_base,
    input  logic [SHIFTW-1:0]       addr_shift,
    input  logic [ADDRW-1:0]        stride,
    input  logic signed [CORDW-1:0] canv_w,
    input  logic signed [CORDW-1:0] canv_h,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic signed [CORDW-1:0] req_x,
    input  logic signed [CORDW-1:0] req_y,
    input  logic [CIDXW-1:0]        req_cidx,
    input  logic                    vram_grant,
    output logic [WORD-1:0]         vram_wmask,
    output logic [ADDRW-1:0]        vram_addr,
    output logic [WORD-1:0]         vram_din,
    output logic                    busy,
    input  logic                    cnt_clr,
    output logic [CNTW-1:0]         cnt_drawn,
    output logic [CNTW-1:0]         cnt_clipped
);
    localparam int LOGW = $clog2(WORD);

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (&v) ? v : v + CNTW'(1);
    endfunction

    function automatic logic [SHIFTW-1:0] shift_decode(input logic [SHIFTW-1:0] s);
        return (s >= SHIFTW'(2) && s <= SHIFTW'(5)) ? s : SHIFTW'(3);
    endfunction

    logic                    vld_p1_q, vld_p1_d;
    logic                    clip_p1_q, clip_p1_d;
    logic signed [CORDW-1:0] x_p1_q, x_p1_d;
    logic [ADDRW-1:0]        line_p1_q, line_p1_d;
    logic [ADDRW-1:0]        base_p1_q, base_p1_d;
    logic [SHIFTW-1:0]       shift_p1_q, shift_p1_d;
    logic [CIDXW-1:0]        cidx_p1_q, cidx_p1_d;

    logic                    vld_p2_q, vld_p2_d;
    logic [WORD-1:0]         vram_wmask_q, vram_wmask_d;
    logic [ADDRW-1:0]        vram_addr_q, vram_addr_d;
    logic [WORD-1:0]         vram_din_q, vram_din_d;
    logic [CNTW-1:0]         cnt_drawn_q, cnt_drawn_d;
    logic [CNTW-1:0]         cnt_clipped_q, cnt_clipped_d;

    logic s2_done, s2_free, s1_drop, s1_adv, accept;

    logic [SHIFTW-1:0]       lbpp;
    logic [LOGW:0]           bpp;
    logic [WORD-1:0]         lowmask;
    logic [CORDW-1:0]        xu, pid, off;
    logic [ADDRW-1:0]        word_off;

    // Handshake: a clipped S1 entry is always dropped, so it never blocks intake.
    always_comb begin
        s2_done   = vld_p2_q & vram_grant;
        s2_free   = ~vld_p2_q | s2_done;
        s1_drop   = vld_p1_q & clip_p1_q;
        s1_adv    = vld_p1_q & ~clip_p1_q & s2_free;
        req_ready = ~rst_sys & (~vld_p1_q | s1_adv | s1_drop);
        accept    = req_valid & req_ready;
    end

    // Stage p1: clip test, line offset, config captured per request
    always_comb begin
        vld_p1_d   = accept | (vld_p1_q & ~s1_adv & ~s1_drop);
        clip_p1_d  = clip_p1_q;
        x_p1_d     = x_p1_q;
        line_p1_d  = line_p1_q;
        base_p1_d  = base_p1_q;
        shift_p1_d = shift_p1_q;
        cidx_p1_d  = cidx_p1_q;
        if (accept) begin
            clip_p1_d  = req_x[CORDW-1] | req_y[CORDW-1] |
                         (req_x >= canv_w) | (req_y >= canv_h);
            x_p1_d     = req_x;
            line_p1_d  = ADDRW'($unsigned(req_y)) * stride;
            base_p1_d  = addr_base;
            shift_p1_d = shift_decode(addr_shift);
            cidx_p1_d  = req_cidx;
        end
    end

    // Stage p2: word address, lane mask and lane-aligned colour data
    always_comb begin
        lbpp     = SHIFTW'(LOGW) - shift_p1_q;
        bpp      = {{LOGW{1'b0}}, 1'b1} << lbpp;
        lowmask  = ~({WORD{1'b1}} << bpp);
        xu       = $unsigned(x_p1_q);
        pid      = xu & ((CORDW'(1) << shift_p1_q) - CORDW'(1));
        off      = pid << lbpp;
        word_off = ADDRW'(xu >> shift_p1_q);

        vld_p2_d     = s1_adv | (vld_p2_q & ~s2_done);
        vram_wmask_d = vram_wmask_q;
        vram_addr_d  = vram_addr_q;
        vram_din_d   = vram_din_q;
        if (s1_adv) begin
            vram_wmask_d = lowmask << off;
            vram_addr_d  = base_p1_q + line_p1_q + word_off;
            vram_din_d   = (WORD'(cidx_p1_q) & lowmask) << off;
        end else if (s2_done) begin
            vram_wmask_d = '0;
        end

        cnt_drawn_d   = cnt_drawn_q;
        cnt_clipped_d = cnt_clipped_q;
        if (cnt_clr) begin
            cnt_drawn_d   = '0;
            cnt_clipped_d = '0;
        end else begin
            if (s2_done) cnt_drawn_d = sat_inc(cnt_drawn_q);
            if (s1_drop) cnt_clipped_d = sat_inc(cnt_clipped_q);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            vld_p1_q      <= 1'b0;
            vld_p2_q      <= 1'b0;
            vram_wmask_q  <= '0;
            vram_addr_q   <= '0;
            vram_din_q    <= '0;
            cnt_drawn_q   <= '0;
            cnt_clipped_q <= '0;
        end else begin
            vld_p1_q      <= vld_p1_d;
            vld_p2_q      <= vld_p2_d;
            vram_wmask_q  <= vram_wmask_d;
            vram_addr_q   <= vram_addr_d;
            vram_din_q    <= vram_din_d;
            cnt_drawn_q   <= cnt_drawn_d;
            cnt_clipped_q <= cnt_clipped_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        clip_p1_q  <= clip_p1_d;
        x_p1_q     <= x_p1_d;
        line_p1_q  <= line_p1_d;
        base_p1_q  <= base_p1_d;
        shift_p1_q <= shift_p1_d;
        cidx_p1_q  <= cidx_p1_d;
    end

    assign vram_wmask  = vram_wmask_q;
    assign vram_addr   = vram_addr_q;
    assign vram_din    = vram_din_q;
    assign busy        = vld_p1_q | vld_p2_q;
    assign cnt_drawn   = cnt_drawn_q;
    assign cnt_clipped = cnt_clipped_q;
endmodule

// File: tb/tb_canv_pix_write.sv
// Bench for canv_pix_write: directed draw requests, a queue-based reference model
// checked every cycle, and literal expectations for the key vectors.
module tb_canv_pix_write;
    logic               clk_sys = 1'b0;
    logic               rst_sys;
    logic [13:0]        addr_base;
    logic [2:0]         addr_shift;
    logic [13:0]        stride;
    logic signed [15:0] canv_w, canv_h;
    logic               req_valid;
    logic               req_ready;
    logic signed [15:0] req_x, req_y;
    logic [7:0]         req_cidx;
    logic               vram_grant;
    logic [31:0]        vram_wmask;
    logic [13:0]        vram_addr;
    logic [31:0]        vram_din;
    logic               busy;
    logic               cnt_clr;
    logic [15:0]        cnt_drawn, cnt_clipped;

    canv_pix_write dut (
        .clk_sys(clk_sys), .rst_sys(rst_sys), .addr_base(addr_base), .addr_shift(addr_shift),
        .stride(stride), .canv_w(canv_w), .canv_h(canv_h), .req_valid(req_valid),
        .req_ready(req_ready), .req_x(req_x), .req_y(req_y), .req_cidx(req_cidx),
        .vram_grant(vram_grant), .vram_wmask(vram_wmask), .vram_addr(vram_addr),
        .vram_din(vram_din), .busy(busy), .cnt_clr(cnt_clr), .cnt_drawn(cnt_drawn),
        .cnt_clipped(cnt_clipped)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct packed {
        logic [13:0] a;
        logic [31:0] m;
        logic [31:0] d;
    } wr_t;

    int  checks = 0;
    int  errors = 0;
    wr_t q[$];
    int  m_drawn = 0;
    int  m_clipped = 0;
    bit  clip_pend = 0;
    int  cx[3] = '{-1, 320, 10};
    int  cy[3] = '{0, 0, 240};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: pixels-per-word by division, word/lane by quotient/remainder.
    function automatic void model_px(input int x, input int y, input int c, input int sh_in,
                                     input int base, input int strd, input int w, input int h,
                                     output bit clip, output wr_t wr);
        int sh, bpp, ppw, pix;
        clip = (x < 0) || (y < 0) || (x >= w) || (y >= h);
        sh   = (sh_in >= 2 && sh_in <= 5) ? sh_in : 3;
        bpp  = 32 >> sh;
        ppw  = 32 / bpp;
        pix  = clip ? 0 : x % ppw;
        wr.a = clip ? 14'd0 : 14'((base + y * strd + x / ppw) % 16384);
        wr.m = 32'(((1 << bpp) - 1) << (pix * bpp));
        wr.d = 32'((c % (1 << bpp)) << (pix * bpp));
    endfunction

    always @(negedge clk_sys) begin
        bit  clip;
        wr_t wr;
        bit  done;
        if (rst_sys) begin
            chk("rst_req_ready", 32'(req_ready), 32'd0);
            q.delete();
            m_drawn   = 0;
            m_clipped = 0;
            clip_pend = 0;
        end else begin
            chk("cnt_drawn", 32'(cnt_drawn), 32'(m_drawn));
            chk("cnt_clipped", 32'(cnt_clipped), 32'(m_clipped));
            if (vram_wmask != 32'd0) begin
                if (q.size() == 0) chk("spurious_wmask", vram_wmask, 32'd0);
                else begin
                    chk("model_addr", 32'(vram_addr), 32'(q[0].a));
                    chk("model_wmask", vram_wmask, q[0].m);
                    chk("model_din", vram_din, q[0].d);
                end
            end
            done = (vram_wmask != 32'd0) && vram_grant;
            if (cnt_clr) begin
                m_drawn   = 0;
                m_clipped = 0;
            end else begin
                if (done && m_drawn < 65535) m_drawn++;
                if (clip_pend && m_clipped < 65535) m_clipped++;
            end
            clip_pend = 0;
            if (done && q.size() > 0) void'(q.pop_front());
            if (req_valid && req_ready) begin
                model_px(int'(req_x), int'(req_y), int'(req_cidx), int'(addr_shift),
                         int'(addr_base), int'(stride), int'(canv_w), int'(canv_h), clip, wr);
                if (clip) clip_pend = 1;
                else q.push_back(wr);
            end
        end
    end

    task automatic send(input logic signed [15:0] x, input logic signed [15:0] y, input logic [7:0] c);
        int n = 0;
        req_x = x; req_y = y; req_cidx = c; req_valid = 1'b1;
        @(negedge clk_sys);
        while (!req_ready && n < 50) begin
            @(negedge clk_sys);
            n++;
        end
        chk("send_ready", 32'(req_ready), 32'd1);
        @(posedge clk_sys); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk_sys);
        while (busy && n < 100) begin
            @(negedge clk_sys);
            n++;
        end
        chk("idle", 32'(busy), 32'd0);
        @(posedge clk_sys); #1;
    endtask

    task automatic single(input int x, input int y, input int c, input logic [31:0] ea,
                          input logic [31:0] em, input logic [31:0] ed, input string tag);
        send(16'(x), 16'(y), 8'(c));
        @(negedge clk_sys);
        chk({tag, "_s1_wmask"}, vram_wmask, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        @(negedge clk_sys);
        chk({tag, "_addr"}, 32'(vram_addr), ea);
        chk({tag, "_wmask"}, vram_wmask, em);
        chk({tag, "_din"}, vram_din, ed);
        @(posedge clk_sys); #1;
    endtask

    task automatic cfg(input int sh, input int base, input int strd);
        addr_shift = 3'(sh); addr_base = 14'(base); stride = 14'(strd);
        canv_w = 16'sd320; canv_h = 16'sd240;
    endtask

    task automatic clr_pulse();
        cnt_clr = 1'b1;
        @(posedge clk_sys); #1;
        cnt_clr = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit  pc;
        wr_t pw;
        rst_sys = 1'b1; req_valid = 1'b0; req_x = '0; req_y = '0; req_cidx = '0;
        vram_grant = 1'b1; cnt_clr = 1'b0;
        cfg(3, 0, 40);

        model_px(10, 2, 26, 3, 0, 40, 320, 240, pc, pw);
        chk("pin_model_addr", 32'(pw.a), 32'd81);
        chk("pin_model_wmask", pw.m, 32'h0000_0F00);
        chk("pin_model_din", pw.d, 32'h0000_0A00);
        model_px(7, 1, 195, 2, 0, 80, 320, 240, pc, pw);
        chk("pin_model_8bpp_wmask", pw.m, 32'hFF00_0000);
        model_px(320, 0, 1, 3, 0, 40, 320, 240, pc, pw);
        chk("pin_model_clip", 32'(pc), 32'd1);

        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        chk("rst_wmask", vram_wmask, 32'd0);
        chk("rst_addr", 32'(vram_addr), 32'd0);
        chk("rst_din", vram_din, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_cnt_drawn", 32'(cnt_drawn), 32'd0);
        chk("rst_cnt_clipped", 32'(cnt_clipped), 32'd0);
        @(posedge clk_sys); #1;
        rst_sys = 1'b0;
        wait_idle();

        // 4bpp basic write
        single(10, 2, 8'h1A, 32'd81, 32'h0000_0F00, 32'h0000_0A00, "t1_4bpp");
        @(negedge clk_sys);
        chk("t1_cnt_drawn", 32'(cnt_drawn), 32'd1);
        @(posedge clk_sys); #1;

        cfg(5, 0, 10);
        wait_idle();
        single(33, 0, 8'h01, 32'd1, 32'h0000_0002, 32'h0000_0002, "t2_1bpp");
        wait_idle();

        cfg(2, 0, 80);
        single(7, 1, 8'hC3, 32'd81, 32'hFF00_0000, 32'hC300_0000, "t3_8bpp");
        wait_idle();
        cfg(6, 100, 40);
        single(10, 2, 8'h1A, 32'd181, 32'h0000_0F00, 32'h0000_0A00, "t3_shift6");
        wait_idle();
        cfg(3, 16380, 40);
        single(40, 0, 8'h17, 32'd1, 32'h0000_000F, 32'h0000_0007, "t3_wrap");
        wait_idle();

        // Clipping, plus the last on-canvas pixel
        cfg(3, 0, 40);
        clr_pulse();
        for (int i = 0; i < 3; i++) begin
            req_x = 16'(cx[i]); req_y = 16'(cy[i]); req_cidx = 8'h5; req_valid = 1'b1;
            @(negedge clk_sys);
            chk("t4_clip_ready", 32'(req_ready), 32'd1);
            @(posedge clk_sys); #1;
        end
        req_valid = 1'b0;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        chk("t4_cnt_clipped", 32'(cnt_clipped), 32'd3);
        chk("t4_cnt_drawn", 32'(cnt_drawn), 32'd0);
        @(posedge clk_sys); #1;
        single(319, 239, 8'h05, 32'd9599, 32'hF000_0000, 32'h5000_0000, "t4_edge");
        wait_idle();

        // Back-to-back with a 3-cycle grant stall on the second write
        clr_pulse();
        fork
            begin
                send(0, 0, 8'h1); send(1, 0, 8'h2); send(8, 0, 8'h3); send(9, 1, 8'h4);
            end
            begin
                int n = 0;
                @(negedge clk_sys);
                while (vram_wmask == 32'd0 && n < 20) begin
                    @(negedge clk_sys);
                    n++;
                end
                chk("t5_first_write_seen", 32'(vram_wmask != 32'd0), 32'd1);
                @(posedge clk_sys); #1;
                vram_grant = 1'b0;
                @(negedge clk_sys);
                chk("t5_stall_ready", 32'(req_ready), 32'd0);
                chk("t5_stall_busy", 32'(busy), 32'd1);
                repeat (3) @(posedge clk_sys);
                #1 vram_grant = 1'b1;
            end
        join
        wait_idle();
        @(negedge clk_sys);
        chk("t5_cnt_drawn", 32'(cnt_drawn), 32'd4);
        @(posedge clk_sys); #1;

        // Counter saturation, then clear coincident with a completing write
        clr_pulse();
        req_x = -16'sd1; req_y = 16'sd0; req_valid = 1'b1;
        repeat (65540) @(posedge clk_sys);
        #1 req_valid = 1'b0;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        chk("t6_sat_clipped", 32'(cnt_clipped), 32'h0000_FFFF);
        @(posedge clk_sys); #1;
        vram_grant = 1'b0;
        send(5, 0, 8'h3);
        begin
            int n = 0;
            @(negedge clk_sys);
            while (vram_wmask == 32'd0 && n < 20) begin
                @(negedge clk_sys);
                n++;
            end
            chk("t6_write_pending", 32'(vram_wmask != 32'd0), 32'd1);
        end
        @(posedge clk_sys); #1;
        vram_grant = 1'b1; cnt_clr = 1'b1;
        @(posedge clk_sys); #1;
        cnt_clr = 1'b0;
        @(negedge clk_sys);
        chk("t6_clr_drawn", 32'(cnt_drawn), 32'd0);
        chk("t6_clr_clipped", 32'(cnt_clipped), 32'd0);
        chk("t6_clr_wmask", vram_wmask, 32'd0);
        @(posedge clk_sys); #1;

        // Reset with both stages occupied
        single(3, 0, 8'h2, 32'd0, 32'h0000_F000, 32'h0000_2000, "t7_pre");
        wait_idle();
        vram_grant = 1'b0;
        send(1, 1, 8'h1); send(2, 1, 8'h2);
        @(negedge clk_sys);
        chk("t7_full_busy", 32'(busy), 32'd1);
        chk("t7_full_wmask", 32'(vram_wmask != 32'd0), 32'd1);
        chk("t7_cnt_before", 32'(cnt_drawn), 32'd1);
        @(posedge clk_sys); #1;
        rst_sys = 1'b1;
        @(negedge clk_sys);
        chk("t7_rst_ready", 32'(req_ready), 32'd0);
        @(posedge clk_sys); #1;
        rst_sys = 1'b0; vram_grant = 1'b1;
        @(negedge clk_sys);
        chk("t7_wmask", vram_wmask, 32'd0);
        chk("t7_busy", 32'(busy), 32'd0);
        chk("t7_cnt_drawn", 32'(cnt_drawn), 32'd0);
        chk("t7_cnt_clipped", 32'(cnt_clipped), 32'd0);
        @(posedge clk_sys); #1;

        single(10, 2, 8'h1A, 32'd81, 32'h0000_0F00, 32'h0000_0A00, "t8_post_rst");
        wait_idle();
        repeat (2) @(posedge clk_sys);
        chk("model_queue_drained", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
